// File: rtl/ux607_perips_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ux607_perips_pkg
// Brief    : Shared definitions for the ux607 peripheral fabric: software
//            operation encoding and the per-bit operation helper.
// Revision : 1.0 - initial release
// ============================================================================
package ux607_perips_pkg;

    // Two-bit software operation field
    typedef logic [1:0] op_t;

    localparam op_t OP_WRITE  = 2'd0;
    localparam op_t OP_SET    = 2'd1;
    localparam op_t OP_CLEAR  = 2'd2;
    localparam op_t OP_TOGGLE = 2'd3;

    // Result of applying one software operation to a single register bit
    function automatic logic apply_op(input op_t op, input logic cur, input logic wdata);
        logic res;
        res = cur;
        case (op)
            OP_WRITE:  res = wdata;
            OP_SET:    res = 1'b1;
            OP_CLEAR:  res = 1'b0;
            OP_TOGGLE: res = ~cur;
            default:   res = cur;
        endcase
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ux607_async_reset_reg_cell.sv
`default_nettype none
// ============================================================================
// Module   : ux607_async_reset_reg_cell
// Brief    : One register bit: hardware-event synchroniser, rising-edge
//            detector, software/hardware next-state merge and the state flop.
// Revision : 1.0 - initial release
// ============================================================================
module ux607_async_reset_reg_cell
    import ux607_perips_pkg::*;
#(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_BIT   = 1'b0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       sw_en,
    input  logic [1:0] op,
    input  logic       wdata,
    input  logic       hw_set,
    output logic       q,
    output logic       change
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   prev_q;
    logic                   prev_d;
    logic                   bit_q;
    logic                   bit_d;
    logic                   hw_rise;

    // Next-state: shift the synchroniser, track the edge flop, merge software op
    // with the hardware event (the event always wins so it is never dropped)
    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], hw_set};
        prev_d  = sync_q[SYNC_STAGES-1];
        hw_rise = sync_q[SYNC_STAGES-1] & ~prev_q;
        bit_d   = bit_q;
        if (sw_en) begin
            bit_d = apply_op(op, bit_q, wdata);
        end
        if (hw_rise) begin
            bit_d = 1'b1;
        end
    end

    // State flops; reset discards any in-flight synchronised event
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            bit_q  <= RESET_BIT;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
            bit_q  <= bit_d;
        end
    end

    assign q      = bit_q;
    assign change = bit_d ^ bit_q;

endmodule
`default_nettype wire

// File: rtl/ux607_async_reset_reg_vec_ctl.sv
`default_nettype none
// ============================================================================
// Module   : ux607_async_reset_reg_vec_ctl
// Brief    : Parametrised control/status register vector with masked software
//            write/set/clear/toggle, synchronised hardware set events and a
//            registered one-cycle change-notification pulse.
// Revision : 1.0 - initial release
// ============================================================================
module ux607_async_reset_reg_vec_ctl
    import ux607_perips_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VAL   = '0,
    parameter int               SYNC_STAGES = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             io_en,
    input  logic [1:0]       io_op,
    input  logic [WIDTH-1:0] io_d,
    input  logic [WIDTH-1:0] io_mask,
    input  logic [WIDTH-1:0] io_hw_set,
    output logic [WIDTH-1:0] io_q,
    output logic             io_changed
);

    logic [WIDTH-1:0] bit_q;
    logic [WIDTH-1:0] bit_change;
    logic [WIDTH-1:0] sw_en_bit;
    logic             changed_q;
    logic             changed_d;

    // Per-bit software enable: strobe qualified by the operation mask
    always_comb begin
        sw_en_bit = {WIDTH{io_en}} & io_mask;
    end

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            ux607_async_reset_reg_cell #(
                .SYNC_STAGES (SYNC_STAGES),
                .RESET_BIT   (RESET_VAL[i])
            ) u_cell (
                .clock  (clock),
                .reset  (reset),
                .sw_en  (sw_en_bit[i]),
                .op     (io_op),
                .wdata  (io_d[i]),
                .hw_set (io_hw_set[i]),
                .q      (bit_q[i]),
                .change (bit_change[i])
            );
        end
    endgenerate

    // Any bit about to change raises the notification for the following cycle
    always_comb begin
        changed_d = |bit_change;
    end

    // Change-notification flop, updated on the same edge as the register bits
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            changed_q <= 1'b0;
        end else begin
            changed_q <= changed_d;
        end
    end

    assign io_q       = bit_q;
    assign io_changed = changed_q;

endmodule
`default_nettype wire

// File: tb/tb_ux607_async_reset_reg_vec_ctl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ux607_async_reset_reg_vec_ctl
// Brief    : Scoreboard bench: a vector-level reference model predicts io_q and
//            io_changed for every edge; a monitor compares each cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ux607_async_reset_reg_vec_ctl;
    import ux607_perips_pkg::*;

    localparam int         W    = 8;
    localparam logic [7:0] RST  = 8'hA5;
    localparam int         S    = 2;

    logic       clock = 1'b0;
    logic       reset;
    logic       io_en;
    logic [1:0] io_op;
    logic [7:0] io_d;
    logic [7:0] io_mask;
    logic [7:0] io_hw_set;
    logic [7:0] io_q;
    logic       io_changed;

    int errors = 0;
    int checks = 0;

    logic [8:0] sb[$];
    logic [7:0] hist[$];
    logic [7:0] m_q;
    logic [7:0] m_old;
    logic [7:0] m_rise;
    logic [7:0] m_m;
    logic [8:0] m_exp;

    ux607_async_reset_reg_vec_ctl #(
        .WIDTH       (W),
        .RESET_VAL   (RST),
        .SYNC_STAGES (S)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .io_en      (io_en),
        .io_op      (io_op),
        .io_d       (io_d),
        .io_mask    (io_mask),
        .io_hw_set  (io_hw_set),
        .io_q       (io_q),
        .io_changed (io_changed)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic en, input op_t op, input logic [7:0] d, input logic [7:0] m);
        io_en   = en;
        io_op   = op;
        io_d    = d;
        io_mask = m;
    endtask

    // Reference model: vector arithmetic on the register; a hardware event is
    // the input level sampled S edges ago being 1 while the sample before was 0
    always @(posedge clock) begin
        if (!reset) begin
            m_q = RST;
            hist.delete();
            for (int i = 0; i < S + 2; i++) hist.push_front(8'h00);
            sb.push_back({m_q, 1'b0});
        end else begin
            m_old = m_q;
            hist.push_front(io_hw_set);
            void'(hist.pop_back());
            m_rise = hist[S] & ~hist[S+1];
            m_m    = io_en ? io_mask : 8'h00;
            case (io_op)
                OP_WRITE:  m_q = (m_q & ~m_m) | (io_d & m_m);
                OP_SET:    m_q = m_q | m_m;
                OP_CLEAR:  m_q = m_q & ~m_m;
                default:   m_q = m_q ^ m_m;
            endcase
            m_q = m_q | m_rise;
            sb.push_back({m_q, m_q != m_old});
        end
    end

    // Monitor: the DUT presents a value every cycle; compare against the queue
    always begin
        @(posedge clock);
        #1;
        if (sb.size() == 0) begin
            chk("sb_underflow", 8'h01, 8'h00);
        end else begin
            m_exp = sb.pop_front();
            chk("sb_q", io_q, m_exp[8:1]);
            chk("sb_changed", {7'b0, io_changed}, {7'b0, m_exp[0]});
        end
    end

    initial begin
        reset = 1'b0;
        io_hw_set = 8'h00;
        drive(1'b0, OP_WRITE, 8'h00, 8'h00);
        repeat (3) @(negedge clock);
        chk("reset_q", io_q, 8'hA5);
        chk("reset_chg", {7'b0, io_changed}, 8'h00);
        reset = 1'b1;

        // Masked write from reset value, then the same write again
        drive(1'b1, OP_WRITE, 8'h3C, 8'h0F);
        @(negedge clock);
        chk("write_q", io_q, 8'hAC);
        chk("write_chg", {7'b0, io_changed}, 8'h01);
        @(negedge clock);
        chk("rewrite_q", io_q, 8'hAC);
        chk("rewrite_chg", {7'b0, io_changed}, 8'h00);

        // Toggle everything, then reset mid-cycle while the pulse is high
        drive(1'b1, OP_TOGGLE, 8'h00, 8'hFF);
        @(negedge clock);
        chk("toggle_q", io_q, 8'h53);
        chk("toggle_chg", {7'b0, io_changed}, 8'h01);
        #2 reset = 1'b0;
        #1;
        chk("async_q", io_q, 8'hA5);
        chk("async_chg", {7'b0, io_changed}, 8'h00);
        drive(1'b0, OP_WRITE, 8'h00, 8'h00);
        repeat (2) @(negedge clock);
        reset = 1'b1;

        // SET / TOGGLE / CLEAR sequence from zero
        drive(1'b1, OP_WRITE, 8'h00, 8'hFF);
        @(negedge clock);
        drive(1'b1, OP_SET, 8'h00, 8'h81);
        @(negedge clock);
        chk("seq_set", io_q, 8'h81);
        drive(1'b1, OP_TOGGLE, 8'h00, 8'hFF);
        @(negedge clock);
        chk("seq_toggle", io_q, 8'h7E);
        drive(1'b1, OP_CLEAR, 8'h00, 8'h70);
        @(negedge clock);
        chk("seq_clear", io_q, 8'h0E);
        drive(1'b1, OP_WRITE, 8'h00, 8'hFF);
        @(negedge clock);

        // Hardware event on bit 3: visible after edge k+S only
        drive(1'b0, OP_WRITE, 8'h00, 8'h00);
        io_hw_set[3] = 1'b1;
        @(negedge clock);
        chk("hw3_k", io_q, 8'h00);
        @(negedge clock);
        chk("hw3_k1", io_q, 8'h00);
        @(negedge clock);
        chk("hw3_k2", io_q, 8'h08);
        chk("hw3_chg", {7'b0, io_changed}, 8'h01);
        @(negedge clock);
        chk("hw3_chg_end", {7'b0, io_changed}, 8'h00);

        // Hardware event on bit 5 beats a simultaneous CLEAR of all bits
        drive(1'b1, OP_WRITE, 8'hFF, 8'hFF);
        io_hw_set[5] = 1'b1;
        @(negedge clock);
        drive(1'b0, OP_WRITE, 8'h00, 8'h00);
        @(negedge clock);
        drive(1'b1, OP_CLEAR, 8'h00, 8'hFF);
        @(negedge clock);
        chk("hw5_vs_clear", io_q, 8'h20);
        drive(1'b0, OP_WRITE, 8'h00, 8'h00);

        // Bit 0 input held high across reset deassertion
        io_hw_set = 8'h01;
        reset = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        drive(1'b1, OP_CLEAR, 8'h00, 8'h01);
        @(negedge clock);
        chk("hold0_k", io_q, 8'hA4);
        drive(1'b0, OP_WRITE, 8'h00, 8'h00);
        @(negedge clock);
        chk("hold0_k1", io_q, 8'hA4);
        @(negedge clock);
        chk("hold0_k2", io_q, 8'hA5);
        chk("hold0_chg", {7'b0, io_changed}, 8'h01);

        // Reset in the middle of synchronising a bit 1 event
        io_hw_set = 8'h03;
        @(negedge clock);
        #2 reset = 1'b0;
        io_hw_set = 8'h01;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        repeat (5) @(negedge clock);
        chk("midsync_b1", {7'b0, io_q[1]}, {7'b0, RST[1]});
        chk("midsync_q", io_q, 8'hA5);

        // Randomised traffic with sparse hardware input toggles and one reset
        for (int n = 0; n < 400; n++) begin
            @(negedge clock);
            drive(1'($urandom_range(0, 1)), op_t'($urandom_range(0, 3)),
                  8'($urandom), 8'($urandom));
            for (int b = 0; b < W; b++) begin
                if ($urandom_range(0, 7) == 0) io_hw_set[b] = ~io_hw_set[b];
            end
            if (n == 200) reset = 1'b0;
            if (n == 202) reset = 1'b1;
        end

        @(negedge clock);
        drive(1'b0, OP_WRITE, 8'h00, 8'h00);
        repeat (5) @(negedge clock);
        chk("sb_drain", 8'(sb.size()), 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
